// File: rtl/data_mem_responder.sv
// data_mem_responder: zero-latency RAM responder with a memory-mapped console TX FIFO.
module data_mem_responder #(
  parameter logic [31:0] MEM_BASE     = 32'h0001_0000,
  parameter int          MEM_WORDS    = 16384,
  parameter logic [31:0] CONSOLE_ADDR = 32'hFFFF_0000,
  parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_0004,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [31:0] rd_addr_i,
  input  logic [1:0]  rd_size_i,
  output logic [31:0] rd_data_o,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [1:0]  wr_size_i,
  input  logic        wr_enable_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        misalign_o,
  output logic        overflow_o
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [FW:0] DEPTH = (FW + 1)'(FIFO_DEPTH);
  logic [31:0] mem [MEM_WORDS];
  logic [7:0] fifo [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr, wr_ptr;
  logic [FW:0] count;
  logic [31:0] rd_off, wr_off, rd_word, rd_sized, status, wr_shift;
  logic [3:0] be;
  logic rd_hit, wr_hit, rd_mis, wr_mis, full, push_req, push, pop;
  function automatic logic mis(input logic [1:0] size, input logic [1:0] a);
    return size == 2'b00 ? 1'b0 : size == 2'b01 ? a[0] : |a;
  endfunction
  // Offsets relative to MEM_BASE; an address below the base wraps high and misses.
  assign rd_off = rd_addr_i - MEM_BASE;
  assign wr_off = wr_addr_i - MEM_BASE;
  assign rd_hit = rd_off < MEM_BYTES;
  assign wr_hit = wr_off < MEM_BYTES;
  assign rd_mis = mis(rd_size_i, rd_addr_i[1:0]);
  assign wr_mis = mis(wr_size_i, wr_addr_i[1:0]);
  assign rd_word = mem[rd_off[IW+1:2]];
  assign rd_sized = rd_size_i == 2'b00 ? {24'b0, rd_word[8*rd_addr_i[1:0] +: 8]} :
                    rd_size_i == 2'b01 ? {16'b0, rd_addr_i[1] ? rd_word[31:16] : rd_word[15:0]} :
                    rd_word;
  assign full = count == DEPTH;
  assign status = {full, overflow_o, 22'b0, 8'(count)};
  assign rd_data_o = rd_mis ? 32'h0 : rd_hit ? rd_sized :
                     rd_addr_i == STATUS_ADDR ? status : 32'h0;
  assign wr_shift = wr_data_i << {wr_addr_i[1:0], 3'b000};
  assign be = wr_size_i == 2'b00 ? 4'b0001 << wr_addr_i[1:0] :
              wr_size_i == 2'b01 ? 4'b0011 << wr_addr_i[1:0] : 4'b1111;
  assign tx_valid_o = count != '0;
  assign tx_data_o = tx_valid_o ? fifo[rd_ptr] : 8'h00;
  assign pop = tx_valid_o & tx_ready_i;
  assign push_req = wr_enable_i & (wr_addr_i == CONSOLE_ADDR);
  assign push = push_req & (!full | pop);
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow_o <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + FW'(pop);
      wr_ptr <= wr_ptr + FW'(push);
      count <= count + (FW + 1)'(push) - (FW + 1)'(pop);
      overflow_o <= overflow_o | (push_req & full & !pop);
      misalign_o <= misalign_o | rd_mis | (wr_enable_i & wr_mis);
    end
  end
  // Storage arrays are never reset; the FIFO head is masked while empty instead.
  always_ff @(posedge clk_i) begin
    if (push) fifo[wr_ptr] <= wr_data_i[7:0];
    if (wr_enable_i && wr_hit && !wr_mis)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[wr_off[IW+1:2]][8*b +: 8] <= wr_shift[8*b +: 8];
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven RAM checks plus directed FIFO/reset sequences.
module tb_data_mem_responder;
  localparam logic [31:0] CON = 32'hFFFF_0000;
  localparam logic [31:0] STA = 32'hFFFF_0004;
  logic clk = 1'b0, reset_ni = 1'b0;
  logic [31:0] rd_addr = STA, rd_data, wr_addr = '0, wr_data = '0;
  logic [1:0] rd_size = 2'd2, wr_size = 2'd2;
  logic wr_enable = 1'b0, tx_ready = 1'b0, tx_valid, misalign, overflow;
  logic [7:0] tx_data;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic we; logic [31:0] wa; logic [31:0] wd; logic [1:0] ws;
    logic [31:0] ra; logic [1:0] rs; logic [31:0] exp;
  } vec_t;
  vec_t v[19];
  data_mem_responder dut (
    .clk_i(clk), .reset_ni(reset_ni), .rd_addr_i(rd_addr), .rd_size_i(rd_size),
    .rd_data_o(rd_data), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_size_i(wr_size),
    .wr_enable_i(wr_enable), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready), .misalign_o(misalign), .overflow_o(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    wr_enable = 1'b1; wr_addr = CON; wr_size = 2'd0; wr_data = {24'h0, d};
  endtask
  initial begin
    v[0]  = '{1'b1, 32'h0001_0000, 32'hDEADBEEF, 2'd2, STA,          2'd2, 32'h0000_0000};
    v[1]  = '{1'b1, 32'h0001_0001, 32'h0000_00AA, 2'd0, 32'h0001_0000, 2'd2, 32'hDEADBEEF};
    v[2]  = '{1'b0, 32'h0,         32'h0,         2'd0, 32'h0001_0000, 2'd2, 32'hDEADAAEF};
    v[3]  = '{1'b0, 32'h0,         32'h0,         2'd0, 32'h0001_0002, 2'd1, 32'h0000_DEAD};
    v[4]  = '{1'b0, 32'h0,         32'h0,         2'd0, 32'h0001_0000, 2'd1, 32'h0000_AAEF};
    v[5]  = '{1'b0, 32'h0,         32'h0,         2'd0, 32'h0001_0000, 2'd0, 32'h0000_00EF};
    v[6]  = '{1'b0, 32'h0,         32'h0,         2'd0, 32'h0001_0001, 2'd0, 32'h0000_00AA};
    v[7]  = '{1'b0, 32'h0,         32'h0,         2'd0, 32'h0001_0002, 2'd0, 32'h0000_00AD};
    v[8]  = '{1'b1, 32'h0001_0006, 32'h0000_1234, 2'd1, 32'h0001_0003, 2'd0, 32'h0000_00DE};
    v[9]  = '{1'b1, 32'h0001_0004, 32'h0000_0077, 2'd0, 32'h0001_0006, 2'd1, 32'h0000_1234};
    v[10] = '{1'b1, 32'h0001_0005, 32'h0000_0066, 2'd0, 32'h0001_0006, 2'd1, 32'h0000_1234};
    v[11] = '{1'b0, 32'h0,         32'h0,         2'd0, 32'h0001_0004, 2'd2, 32'h1234_6677};
    v[12] = '{1'b1, 32'h0001_FFFC, 32'hCAFEF00D, 2'd2, 32'h0000_FFFC, 2'd2, 32'h0000_0000};
    v[13] = '{1'b1, 32'h0002_0000, 32'h1111_1111, 2'd2, 32'h0001_FFFC, 2'd2, 32'hCAFEF00D};
    v[14] = '{1'b0, 32'h0,         32'h0,         2'd0, 32'h0002_0000, 2'd2, 32'h0000_0000};
    v[15] = '{1'b0, 32'h0,         32'h0,         2'd0, 32'h0001_0000, 2'd2, 32'hDEADAAEF};
    v[16] = '{1'b1, 32'h0000_FFFC, 32'h9999_9999, 2'd2, 32'h0001_FFFE, 2'd1, 32'h0000_CAFE};
    v[17] = '{1'b0, 32'h0,         32'h0,         2'd0, 32'h0001_FFFC, 2'd2, 32'hCAFEF00D};
    v[18] = '{1'b0, 32'h0,         32'h0,         2'd0, 32'h0001_0000, 2'd3, 32'hDEADAAEF};
    #1;
    chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("reset_tx_data", {24'b0, tx_data}, 32'h0);
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      wr_enable = v[i].we; wr_addr = v[i].wa; wr_data = v[i].wd; wr_size = v[i].ws;
      rd_addr = v[i].ra; rd_size = v[i].rs;
      #1 chk($sformatf("vec%0d", i), rd_data, v[i].exp);
    end
    @(negedge clk);
    wr_enable = 1'b0;
    #1 chk("no_misalign_yet", {31'b0, misalign}, 32'h0);
    // misaligned half write is dropped and flags on the next edge
    @(negedge clk);
    wr_enable = 1'b1; wr_addr = 32'h0001_0003; wr_data = 32'h0000_BBBB; wr_size = 2'd1;
    rd_addr = 32'h0001_0000; rd_size = 2'd2;
    #1 chk("misalign_pre", {31'b0, misalign}, 32'h0);
    @(negedge clk);
    wr_enable = 1'b0;
    #1 chk("misalign_set", {31'b0, misalign}, 32'h1);
    chk("mis_wr_dropped", rd_data, 32'hDEADAAEF);
    rd_addr = 32'h0; #1 chk("unmapped_rd", rd_data, 32'h0);
    rd_addr = 32'h0001_0001; rd_size = 2'd1; #1 chk("mis_rd_zero", rd_data, 32'h0);
    rd_addr = STA; rd_size = 2'd2;
    @(negedge clk); reset_ni = 1'b0;
    #1 chk("misalign_clr", {31'b0, misalign}, 32'h0);
    @(negedge clk); reset_ni = 1'b1;
    // fill, overflow, drain
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_byte(8'h41 + 8'(i));
      if (i == 0) #1 chk("no_bypass", {31'b0, tx_valid}, 32'h0);
    end
    @(negedge clk); wr_enable = 1'b0;
    #1 chk("status_full", rd_data, 32'h8000_0008);
    chk("head_A", {24'b0, tx_data}, 32'h41);
    chk("ovf_pre", {31'b0, overflow}, 32'h0);
    push_byte(8'h49);
    @(negedge clk); wr_enable = 1'b0;
    #1 chk("ovf_set", {31'b0, overflow}, 32'h1);
    chk("status_ovf", rd_data, 32'hC000_0008);
    chk("head_stable", {24'b0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'h41 + 8'(i)});
      @(negedge clk); #1;
    end
    chk("drained", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    @(negedge clk); reset_ni = 1'b0;
    @(negedge clk); reset_ni = 1'b1;
    // push+pop while full
    for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
    push_byte(8'h5A);
    tx_ready = 1'b1;
    #1 chk("pp_head", {24'b0, tx_data}, 32'h30);
    @(negedge clk); wr_enable = 1'b0;
    #1 chk("pp_count", rd_data, 32'h8000_0008);
    chk("pp_no_ovf", {31'b0, overflow}, 32'h0);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("pp_drain%0d", j), {24'b0, tx_data}, {24'b0, j < 7 ? 8'h31 + 8'(j) : 8'h5A});
      @(negedge clk); #1;
    end
    chk("pp_empty", {31'b0, tx_valid}, 32'h0);
    // asynchronous reset mid-drain
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h70 + 8'(i));
    @(negedge clk);
    wr_enable = 1'b0; tx_ready = 1'b1; rd_addr = 32'h0001_0002;
    @(negedge clk);
    rd_addr = STA; tx_ready = 1'b1;
    #1 chk("md_misalign", {31'b0, misalign}, 32'h1);
    chk("md_count", rd_data, 32'h0000_0003);
    chk("md_head", {24'b0, tx_data}, 32'h71);
    #2 reset_ni = 1'b0;
    #1 chk("rst_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_data", {24'b0, tx_data}, 32'h0);
    chk("rst_flags", {30'b0, misalign, overflow}, 32'h0);
    rd_addr = 32'h0001_0000;
    #1 chk("rst_ram_kept", rd_data, 32'hDEADAAEF);
    @(negedge clk);
    reset_ni = 1'b1; tx_ready = 1'b0; rd_addr = STA;
    #1 chk("rst_status", rd_data, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
